// File: rtl/cnt_speed_sched.sv
// Speed scheduler: debounces up/down buttons, ramps the applied speed toward a
// target one step per RAMP_CYC cycles, and emits a count tick whose period halves per level.
module cnt_speed_sched #(
  parameter int SPEED_W       = 3,
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int RAMP_CYC      = 50_000_000,
  parameter int BASE_DIV_LOG2 = 26
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_up_i,
  input  logic               btn_dn_i,
  input  logic               pause_i,
  output logic [SPEED_W-1:0] set_speed_o,
  output logic               cnt_tick_o,
  output logic               ramping_o,
  output logic               paused_o
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RT_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RT_W-1:0]    RT_LAST   = RT_W'(RAMP_CYC - 1);
  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 raw, filt, filt_d, press;
  logic [1:0][DB_W-1:0]       db_cnt;
  logic [SPEED_W-1:0]         cur, tgt, cur_step;
  logic [RT_W-1:0]            ramp_t, ramp_d;
  logic [BASE_DIV_LOG2-1:0]   div, lim;
  logic                       step, counting;

  // bit 0 = up button, bit 1 = down button
  assign raw = {btn_dn_i, btn_up_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt <= '0;
      filt   <= '0;
      filt_d <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != filt[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            filt[i]   <= raw[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      filt_d <= filt;
      press  <= filt & ~filt_d;
    end
  end

  // Simultaneous up and down presses cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt <= '0;
    end else if (press[0] && !press[1] && tgt != SPEED_MAX) begin
      tgt <= tgt + 1'b1;
    end else if (press[1] && !press[0] && tgt != '0) begin
      tgt <= tgt - 1'b1;
    end
  end

  assign cur_step = (tgt > cur) ? cur + 1'b1 : cur - 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= HOLD;
    else       state_q <= state_d;
  end

  // Pause wins over a ramp step; a target that meets cur without a step ends the ramp.
  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_t;
    step    = 1'b0;
    case (state_q)
      HOLD: begin
        ramp_d = '0;
        if (pause_i)         state_d = PAUSE;
        else if (cur != tgt) state_d = RAMP;
      end
      RAMP: begin
        if (pause_i) begin
          state_d = PAUSE;
        end else if (cur == tgt) begin
          state_d = HOLD;
        end else if (ramp_t == RT_LAST) begin
          step   = 1'b1;
          ramp_d = '0;
          if (cur_step == tgt) state_d = HOLD;
        end else begin
          ramp_d = ramp_t + 1'b1;
        end
      end
      PAUSE: begin
        if (!pause_i) state_d = (cur != tgt) ? RAMP : HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ramp_t <= '0;
      cur    <= '0;
    end else begin
      ramp_t <= ramp_d;
      if (step) cur <= cur_step;
    end
  end

  assign lim      = {BASE_DIV_LOG2{1'b1}} >> cur;
  assign counting = (state_q != PAUSE);

  // A speed change restarts the divider so the new period starts cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div <= '0;
    end else if (step) begin
      div <= '0;
    end else if (counting) begin
      div <= (div == lim) ? '0 : div + 1'b1;
    end
  end

  assign cnt_tick_o  = counting && !step && (div == lim);
  assign set_speed_o = cur;
  assign ramping_o   = (state_q == RAMP);
  assign paused_o    = (state_q == PAUSE);

endmodule
